// File: rtl/stream_credit_pkg.sv
// Shared definitions for the stream credit semaphore/release pair.
// Element packing is {tlast, tkeep, tdata} on both sides.
package stream_credit_pkg;

    localparam int DEFAULT_STREAM_WIDTH = 32;
    localparam int DEFAULT_KEEP_WIDTH   = 1;
    localparam int SKID_WIDTH           = 1 + DEFAULT_KEEP_WIDTH + DEFAULT_STREAM_WIDTH;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_credit_release_if.sv
// AXI-Stream bundle used on both sides of stream_credit_release.
interface stream_credit_release_if #(
    parameter int STREAM_WIDTH = 32,
    parameter int KEEP_WIDTH   = 1
) ();

    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [STREAM_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]   tkeep;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tkeep,
        output tready
    );

endinterface

// File: rtl/stream_credit_fifo.sv
// Element storage behind the output register: distributed RAM with
// wrap-by-compare pointers, so DEPTH does not have to be a power of two.
module stream_credit_fifo
    import stream_credit_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = SKID_WIDTH
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Asynchronous read: a same-slot write this cycle still returns the old head.
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_credit_release.sv
// Tail buffer of a non-stallable pipeline: captures every result, forwards it
// on AXI-Stream and returns one semaphore credit per downstream handshake.
module stream_credit_release
    import stream_credit_pkg::*;
#(
    parameter int  MAX_NUMBER_OF_ELEMENTS = 128,
    parameter int  STREAM_WIDTH           = 32,
    parameter int  KEEP_WIDTH             = 1,
    localparam int CNT_W                  = clog2(MAX_NUMBER_OF_ELEMENTS + 1)
) (
    input  logic                          aclk,
    input  logic                          reset,
    stream_credit_release_if.slave        s_axis,
    stream_credit_release_if.master       m_axis,
    output logic                          sigRelease,
    output logic [CNT_W-1:0]              fillLevel,
    output logic                          overflow
);

    localparam int SKID_W = 1 + KEEP_WIDTH + STREAM_WIDTH;

    logic              out_valid;
    logic [SKID_W-1:0] out_data;
    logic [SKID_W-1:0] in_word;
    logic [SKID_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              handshake;
    logic              is_full;
    logic              write_accepted;
    logic              out_load;

    // The pipeline cannot stall, so the sink side always reports ready.
    assign s_axis.tready = 1'b1;

    assign in_word        = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    assign handshake      = out_valid && m_axis.tready;
    assign is_full        = (fillLevel == CNT_W'(MAX_NUMBER_OF_ELEMENTS));
    assign write_accepted = s_axis.tvalid && (!is_full || handshake);
    assign out_load       = !out_valid || handshake;

    // Storage is bypassed only when nothing older waits there.
    assign fifo_pop  = out_load && !fifo_empty;
    assign fifo_push = write_accepted && !(out_load && fifo_empty);

    stream_credit_fifo #(
        .DEPTH (MAX_NUMBER_OF_ELEMENTS),
        .WIDTH (SKID_W)
    ) u_fifo (
        .aclk    (aclk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_word),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    always_ff @(posedge aclk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            fillLevel  <= '0;
            sigRelease <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sigRelease <= handshake;
            fillLevel  <= fillLevel + CNT_W'(write_accepted) - CNT_W'(handshake);
            if (s_axis.tvalid && !write_accepted) begin
                overflow <= 1'b1;
            end
            if (out_load) begin
                out_valid <= !fifo_empty || write_accepted;
            end
        end
    end

    // Payload needs no reset; it is only observed while out_valid is high.
    always_ff @(posedge aclk) begin
        if (out_load) begin
            out_data <= fifo_empty ? in_word : fifo_rd_data;
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data[STREAM_WIDTH-1:0];
    assign m_axis.tkeep  = out_data[STREAM_WIDTH +: KEEP_WIDTH];
    assign m_axis.tlast  = out_data[SKID_W-1];

endmodule

// File: tb/tb_stream_credit_release.sv
// Bench for stream_credit_release: constant vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_stream_credit_release;
    import stream_credit_pkg::*;

    localparam int MAX   = 128;
    localparam int SW    = 32;
    localparam int KW    = 1;
    localparam int CNT_W = clog2(MAX + 1);
    localparam int PW    = 1 + KW + SW;

    logic             aclk = 1'b0;
    logic             reset;
    logic             sigRelease;
    logic [CNT_W-1:0] fillLevel;
    logic             overflow;

    stream_credit_release_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) s_if ();
    stream_credit_release_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) m_if ();

    stream_credit_release #(
        .MAX_NUMBER_OF_ELEMENTS (MAX),
        .STREAM_WIDTH           (SW),
        .KEEP_WIDTH             (KW)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .sigRelease (sigRelease),
        .fillLevel  (fillLevel),
        .overflow   (overflow)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model: the held elements in arrival order, head first.
    logic [PW-1:0] mq[$];
    logic          mOvf;
    logic          mRel;
    int            hsCount;
    int            relCount;

    typedef struct {
        bit          wv;
        logic [31:0] din;
        bit          rdy;
        bit          expValid;
        int          expFill;
        bit          expRel;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] makeElem(input logic last, input logic [KW-1:0] keep,
                                               input logic [SW-1:0] data);
        return {last, keep, data};
    endfunction

    task automatic checkOutput();
        logic [PW-1:0] h;
        check("tvalid", 64'(m_if.tvalid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            h = mq[0];
            check("tdata", 64'(m_if.tdata), 64'(h[SW-1:0]));
            check("tkeep", 64'(m_if.tkeep), 64'(h[SW +: KW]));
            check("tlast", 64'(m_if.tlast), 64'(h[PW-1]));
        end
        check("fillLevel", 64'(fillLevel), 64'(mq.size()));
        check("sigRelease", 64'(sigRelease), 64'(mRel));
        check("overflow", 64'(overflow), 64'(mOvf));
        if (sigRelease === 1'b1) relCount++;
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic applyStimulus(input logic wv, input logic [PW-1:0] elem, input logic rdy);
        logic hs;
        logic acc;
        s_if.tvalid = wv;
        s_if.tlast  = elem[PW-1];
        s_if.tkeep  = elem[SW +: KW];
        s_if.tdata  = elem[SW-1:0];
        m_if.tready = rdy;
        hs  = (mq.size() > 0) && rdy;
        acc = wv && ((mq.size() < MAX) || hs);
        if (wv && !acc) mOvf = 1'b1;
        if (hs) begin
            void'(mq.pop_front());
            hsCount++;
        end
        if (acc) mq.push_back(elem);
        mRel = hs;
        @(posedge aclk);
        #1;
        checkOutput();
    endtask

    task automatic doReset(input logic rdy);
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = rdy;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        mq.delete();
        mOvf = 1'b0;
        mRel = 1'b0;
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_fill", 64'(fillLevel), 64'd0);
        check("rst_release", 64'(sigRelease), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
    endtask

    task automatic drainOutputs(input int limit);
        for (int c = 0; c < limit && mq.size() > 0; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        check("drain_fill", 64'(fillLevel), 64'd0);
    endtask

    task automatic fillBurst(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, makeElem(i[0], 1'(i[1]), 32'h1000 + 32'(i)), 1'b0);
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int credits;
        int sent;

        vecs[0]  = '{1, 32'hA5A5A5A5, 0, 1, 1, 0, 32'hA5A5A5A5};
        vecs[1]  = '{0, 32'h0,        1, 0, 0, 1, 32'h0};
        vecs[2]  = '{0, 32'h0,        1, 0, 0, 0, 32'h0};
        vecs[3]  = '{1, 32'h1,        1, 1, 1, 0, 32'h1};
        vecs[4]  = '{1, 32'h2,        1, 1, 1, 1, 32'h2};
        vecs[5]  = '{1, 32'h3,        0, 1, 2, 0, 32'h2};
        vecs[6]  = '{1, 32'h4,        0, 1, 3, 0, 32'h2};
        vecs[7]  = '{0, 32'h0,        1, 1, 2, 1, 32'h3};
        vecs[8]  = '{0, 32'h0,        1, 1, 1, 1, 32'h4};
        vecs[9]  = '{0, 32'h0,        1, 0, 0, 1, 32'h0};
        vecs[10] = '{0, 32'h0,        0, 0, 0, 0, 32'h0};

        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        hsCount     = 0;
        relCount    = 0;
        repeat (2) @(posedge aclk);
        #1;
        doReset(1'b0);
        check("s_tready", 64'(s_if.tready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].wv, makeElem(1'b0, 1'b1, vecs[i].din), vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), 64'(m_if.tvalid), 64'(vecs[i].expValid));
            check($sformatf("vec%0d_fill", i), 64'(fillLevel), 64'(vecs[i].expFill));
            check($sformatf("vec%0d_rel", i), 64'(sigRelease), 64'(vecs[i].expRel));
            if (vecs[i].expValid) begin
                check($sformatf("vec%0d_data", i), 64'(m_if.tdata), 64'(vecs[i].expData));
            end
        end

        // Fill to the brim, then a write that coincides with a handshake.
        doReset(1'b0);
        relCount = 0;
        fillBurst(MAX);
        check("burst_fill", 64'(fillLevel), 64'(MAX));
        check("burst_overflow", 64'(overflow), 64'd0);
        check("burst_no_release", 64'(relCount), 64'd0);
        applyStimulus(1'b1, makeElem(1'b1, 1'b1, 32'hDEAD_BEEF), 1'b1);
        check("full_hs_fill", 64'(fillLevel), 64'(MAX));
        check("full_hs_overflow", 64'(overflow), 64'd0);
        drainOutputs(400);
        check("burst_release_count", 64'(relCount), 64'(MAX + 1));

        // Full plus a write with no handshake is dropped and flagged.
        doReset(1'b0);
        fillBurst(MAX);
        applyStimulus(1'b1, makeElem(1'b0, 1'b1, 32'hBAD0_0001), 1'b0);
        check("drop_overflow", 64'(overflow), 64'd1);
        check("drop_fill", 64'(fillLevel), 64'(MAX));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0);
        check("overflow_sticky", 64'(overflow), 64'd1);
        drainOutputs(400);
        check("overflow_after_drain", 64'(overflow), 64'd1);

        // Reset mid-operation discards everything and returns no credits.
        doReset(1'b0);
        fillBurst(37);
        check("pre_reset_fill", 64'(fillLevel), 64'd37);
        relCount = 0;
        doReset(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
        check("reset_no_release", 64'(relCount), 64'd0);

        // Random traffic at 50% valid / 50% ready.
        doReset(1'b0);
        hsCount  = 0;
        relCount = 0;
        sent     = 0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            logic wv;
            wv = 1'($urandom_range(0, 1));
            applyStimulus(wv, makeElem(1'($urandom), KW'($urandom), 32'($urandom)),
                          1'($urandom_range(0, 1)));
            if (wv) sent++;
        end
        check("random_sent", 64'(sent), 64'd10000);
        drainOutputs(400);
        check("random_release_count", 64'(relCount), 64'(hsCount));

        // Closed loop with a credit counter standing in for the semaphore.
        doReset(1'b0);
        credits = MAX;
        sent    = 0;
        for (int c = 0; c < 30000 && sent < 3000; c++) begin
            logic wv;
            wv = (credits > 0) && ($urandom_range(0, 3) != 0);
            if (wv) begin
                credits--;
                sent++;
            end
            applyStimulus(wv, makeElem(1'($urandom), KW'($urandom), 32'($urandom)),
                          ($urandom_range(0, 3) == 0));
            if (sigRelease === 1'b1) credits++;
        end
        for (int c = 0; c < 400 && mq.size() > 0; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (sigRelease === 1'b1) credits++;
        end
        check("loop_overflow", 64'(overflow), 64'd0);
        check("loop_credits", 64'(credits), 64'(MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
